// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int ADD3_THRESHOLD = 5;

    // One spare bit so the terminal count WIDTH itself is representable.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(ADD3_THRESHOLD))
            dout = din + BCD_DIGIT_W'(3);
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with a held output register so displays stay stable during the next run.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iStart,
    input  logic [WIDTH-1:0]          iBin,
    output logic                      oReady,
    output logic                      oDone,
    output logic [BCD_DIGIT_W*DIGITS-1:0] oBCD,
    output logic                      oOverflow
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = cnt_width(WIDTH);

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   obcd_d;
    logic            oovf_d, done_d;

    // Per-digit correction applied to the working register before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign oReady = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        obcd_d  = oBCD;
        oovf_d  = oOverflow;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    shift_d = iBin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // The top digit's MSB falls off the end; it marks a value too large.
                {bcd_d, shift_d} = {bcd_adj[BW-2:0], shift_q, 1'b0};
                ovf_d = ovf_q | bcd_adj[BW-1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    obcd_d  = bcd_d;
                    oovf_d  = ovf_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            oBCD      <= '0;
            oOverflow <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            oBCD      <= obcd_d;
            oOverflow <= oovf_d;
            oDone     <= done_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, monitors pop on oDone.
module tb_bin2bcd_seq;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st10, st4;
    logic [31:0] bin10, bin4;
    logic        rdy10, done10, ovf10;
    logic        rdy4, done4, ovf4;
    logic [39:0] bcd10;
    logic [15:0] bcd4;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q10[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut10 (
        .iCLK(clk), .iRST(rst), .iStart(st10), .iBin(bin10),
        .oReady(rdy10), .oDone(done10), .oBCD(bcd10), .oOverflow(ovf10)
    );

    bin2bcd_seq #(.WIDTH(32), .DIGITS(4)) dut4 (
        .iCLK(clk), .iRST(rst), .iStart(st4), .iBin(bin4),
        .oReady(rdy4), .oDone(done4), .oBCD(bcd4), .oOverflow(ovf4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: compare every oDone pulse against the scoreboard head.
    logic prev10 = 1'b0, prev4 = 1'b0;
    always @(negedge clk) begin
        if (!rst && done10) begin
            chk("done10_single", {63'b0, prev10}, 64'd0);
            if (q10.size() == 0) begin
                chk("done10_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q10.pop_front();
                chk("bcd10", {24'b0, bcd10}, {24'b0, e.bcd});
                chk("ovf10", {63'b0, ovf10}, {63'b0, e.ovf});
                chk("lat10", 64'(cyc), 64'(e.cyc));
            end
        end
        prev10 = done10;
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            chk("done4_single", {63'b0, prev4}, 64'd0);
            if (q4.size() == 0) begin
                chk("done4_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("bcd4", {48'b0, bcd4}, {24'b0, e.bcd});
                chk("ovf4", {63'b0, ovf4}, {63'b0, e.ovf});
                chk("lat4", 64'(cyc), 64'(e.cyc));
            end
        end
        prev4 = done4;
    end

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic start10(input logic [31:0] v, input logic [39:0] eb, input logic eo,
                           input bit track);
        int n = 0;
        while (!rdy10 && n < 200) begin n++; @(posedge clk); #1; end
        if (!rdy10) chk("ready10_timeout", 64'd0, 64'd1);
        st10 = 1'b1; bin10 = v;
        if (track) q10.push_back('{bcd: eb, ovf: eo, cyc: cyc + 33});
        @(posedge clk); #1;
        st10 = 1'b0;
    endtask

    task automatic start4(input logic [31:0] v, input logic [15:0] eb, input logic eo);
        int n = 0;
        while (!rdy4 && n < 200) begin n++; @(posedge clk); #1; end
        if (!rdy4) chk("ready4_timeout", 64'd0, 64'd1);
        st4 = 1'b1; bin4 = v;
        q4.push_back('{bcd: {24'b0, eb}, ovf: eo, cyc: cyc + 33});
        @(posedge clk); #1;
        st4 = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; st10 = 1'b0; st4 = 1'b0; bin10 = '0; bin4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'b0, rdy10}, 64'd1);
        chk("rst_done", {63'b0, done10}, 64'd0);
        chk("rst_bcd", {24'b0, bcd10}, 64'd0);
        chk("rst_ovf", {63'b0, ovf10}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        start10(32'd0, 40'h0000000000, 1'b0, 1'b1);

        // oReady must stay low for the 32 conversion steps.
        start10(32'd1234, 40'h0000001234, 1'b0, 1'b1);
        n = 0;
        while (!rdy10 && n < 100) begin n++; @(posedge clk); #1; end
        chk("ready_low_cycles", 64'(n), 64'd32);

        start10(32'hFFFF_FFFF, 40'h4294967295, 1'b0, 1'b1);

        start4(32'd12345, 16'h2345, 1'b1);
        start4(32'd9999, 16'h9999, 1'b0);

        // Ignored start mid-conversion and iBin change after acceptance.
        start10(32'd555, 40'h0000000555, 1'b0, 1'b1);
        bin10 = 32'd888;
        repeat (9) @(posedge clk);
        #1;
        st10 = 1'b1; bin10 = 32'd777;
        @(posedge clk); #1;
        st10 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_queued_start", 64'(q10.size()), 64'd0);

        // Reset mid-conversion discards the result.
        start10(32'd4321, 40'h0, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_bcd", {24'b0, bcd10}, 64'd0);
        chk("midrst_ready", {63'b0, rdy10}, 64'd1);
        chk("midrst_done", {63'b0, done10}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        start10(32'd42, 40'h0000000042, 1'b0, 1'b1);

        // Continuous iStart: three back-to-back conversions, 33 cycles apart.
        n = 0;
        while (!rdy10 && n < 200) begin n++; @(posedge clk); #1; end
        st10 = 1'b1; bin10 = 32'd7;
        for (int i = 0; i < 3; i++)
            q10.push_back('{bcd: 40'h0000000007, ovf: 1'b0, cyc: cyc + 33 + 33 * i});
        repeat (80) @(posedge clk);
        #1;
        st10 = 1'b0;

        n = 0;
        while ((q10.size() != 0 || q4.size() != 0) && n < 300) begin
            n++; @(posedge clk);
        end
        chk("q10_drained", 64'(q10.size()), 64'd0);
        chk("q4_drained", 64'(q4.size()), 64'd0);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. It sits directly upstream of the bcd7seg digit decoders. It replaces the combinational divide/modulo digit extraction on the cycles_consumed and PC display paths, which is expensive and timing-critical. The result is held in an output register, so the seven-segment displays stay stable while the next conversion runs.

Parameters:
WIDTH, 32, bit width of the binary input.
DIGITS, 10, number of BCD digits produced (10 covers the full 32-bit range).

Ports:
iCLK  input  1  system clock.
iRST  input  1  asynchronous, active-high reset.
iStart  input  1  conversion request; sampled only while oReady=1.
iBin  input  WIDTH  unsigned binary value; sampled on the accepting edge only.
oReady  output  1  high in IDLE; the block can accept iStart.
oDone  output  1  one-cycle pulse when oBCD/oOverflow update.
oBCD  output  4*DIGITS  packed BCD result; [3:0] = ones digit, [7:4] = tens digit, and so on.
oOverflow  output  1  value did not fit in DIGITS digits; oBCD then holds value mod 10^DIGITS.

Behaviour:
- One clock (iCLK); reset is asynchronous and active-high (iRST).
- Reset, applied asynchronously at any time including mid-conversion:
  - state=IDLE, oReady=1, oDone=0, oBCD=0, oOverflow=0.
  - Working registers and bit counter cleared.
  - Any conversion in flight is discarded.
- States: IDLE, CONVERT.
- IDLE:
  - oReady=1.
  - On an edge with iStart=1 (edge E0): load the shift register with iBin, clear the BCD working register, counter=0, go to CONVERT.
- CONVERT, one step per edge E1..E_WIDTH:
  - Every working digit >=5 gets +3 (4-bit, no carry between digits).
  - Then the {bcd_work, shift} concatenation shifts left 1.
  - A 1 shifted out of the top working digit sets a sticky overflow flag.
  - Counter increments each step.
- At E_WIDTH (the WIDTH-th step):
  - oBCD <= final working register; oOverflow <= sticky flag.
  - oDone <= 1; state <= IDLE.
- oDone clears on the next edge; it is never high for more than one cycle.
- Latency:
  - oDone is high in the cycle following E_WIDTH, i.e. WIDTH edges after the accepting edge.
  - Throughput is one conversion per WIDTH+1 cycles.
- iStart while oReady=0 is ignored (not queued).
- iStart held high continuously gives back-to-back conversions: re-accepted on the edge after oDone is set.
- iBin changes after E0 do not affect the in-flight result.
- oBCD/oOverflow hold their last value between oDone pulses and change only on the oDone-setting edge.
- Value 0: full WIDTH steps still run (fixed latency); result is all zeros.
- Counter width is clog2(WIDTH)+1 so the WIDTH terminal count is representable.
- Digits are always legal BCD (0-9), including in the overflow case.

Decomposition:
- Shared package bin2bcd_pkg:
  - State enum (IDLE, CONVERT).
  - BCD_DIGIT_W=4.
  - ADD3_THRESHOLD=5.
  - Function computing the counter width.
- One combinational sub-module, bcd_digit_adj (4-bit in, 4-bit out, +3 when input >=5), generated DIGITS times in the step datapath.
- The FSM, counter, shift register and output register stay in bin2bcd_seq.

Test Plan:
- Reset then iBin=0, iStart 1 cycle -> oDone pulses exactly 32 edges later; oBCD=40'h0000000000, oOverflow=0.
- iBin=1234 -> oBCD=40'h0000001234, oOverflow=0; oReady low from E0 until the oDone cycle.
- iBin=32'hFFFFFFFF -> oBCD=40'h4294967295, oOverflow=0.
- DIGITS=4, iBin=12345 -> oBCD=16'h2345, oOverflow=1; then iBin=9999 -> oBCD=16'h9999, oOverflow=0.
- Start iBin=555; pulse iStart with iBin=777 at E10; change iBin to 888 after E0 -> result 12'h555 only; one oDone pulse; no second conversion.
- Start iBin=4321; assert iRST at E16 -> oBCD=0, oDone never pulses, oReady=1 immediately. Then iStart with iBin=42 -> oBCD=...42 after 32 edges.
- Hold iStart=1 with iBin=7 -> an oDone pulse every 33 cycles, each with oBCD=...07.
